line_memory: RTL

- Main-memory model on the 256-bit line interface. It sits directly downstream of the data cache and consumes the CPU's mem_enable/mem_write/mem_addr/mem_data outputs.
- Returns mem_ack/mem_data_i to the CPU after a fixed, parameterised latency, so cache miss, refill and write-back paths are exercised with real multi-cycle stalls.
- One outstanding request at a time; requests are accepted only when idle.

---
 rtl/line_memory_if.sv | 21 ++
 rtl/line_memory.sv | 108 ++++++++++
 2 files changed

// File: rtl/line_memory_if.sv
// Line-memory bus: one-request-at-a-time 256-bit line transfer.
// master = cache side (drives request), slave = memory side (drives ack/data/busy).
interface line_memory_if;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         busy_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o, busy_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o, busy_o
    );
endinterface

// File: rtl/line_memory.sv
// Main-memory model returning 256-bit lines after a fixed latency.
// Ports: clk_i, rst_i (sync, active-high), bus (line_memory_if.slave).
module line_memory #(
    parameter int unsigned LATENCY     = 10,
    parameter int unsigned DEPTH_LINES = 512,
    parameter int unsigned ADDR_LSB    = 5
) (
    input logic          clk_i,
    input logic          rst_i,
    line_memory_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [255:0]       wdata_q, wdata_d;
    logic [255:0]       rdata_q, rdata_d;
    logic               mem_we;
    logic [255:0]       mem_q [DEPTH_LINES];
    logic               unused_addr;

    assign unused_addr = ^{bus.addr_i[31:ADDR_LSB+IDX_W],
                           bus.addr_i[ADDR_LSB-1:0]};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is never cleared; a commit coinciding with reset is dropped.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.enable_i) begin
                    idx_d   = bus.addr_i[ADDR_LSB +: IDX_W];
                    wr_d    = bus.write_i;
                    wdata_d = bus.data_i;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic. The *_d request fields equal the latched values in
    // WAIT and the live inputs on a direct IDLE->ACK accept, so the
    // commit always sees the right request.
    always_comb begin
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        if (state_d == S_ACK && state_q != S_ACK) begin
            mem_we  = wr_d & ~rst_i;
            rdata_d = wr_d ? wdata_d : mem_q[idx_d];
        end
    end

    assign bus.ack_o  = (state_q == S_ACK);
    assign bus.busy_o = (state_q != S_IDLE);
    assign bus.data_o = rdata_q;

endmodule
